// File: rtl/uart_pkg.sv
// Shared UART encodings: parity selection, transmit FSM states and defaults.
package uart_pkg;

   localparam logic [1:0] PAR_NONE  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_EVEN  = 2'b10;
   localparam logic [1:0] PAR_NONE2 = 2'b11;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;
   localparam int unsigned DATA_BITS_DEF    = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // True when the frame carries a parity bit.
   function automatic logic parity_enabled(input logic [1:0] ptype);
      return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
   endfunction

endpackage

// File: rtl/uart_parity.sv
// Parity bit generator: odd/even parity over one data word, 0 when disabled.
module uart_parity
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
   input  logic [DATA_BITS-1:0] data_i,
   input  logic [1:0]           parity_type_i,
   output logic                 par_bit_c_o
);

   logic xor_c;

   assign xor_c = ^data_i;

   // Odd parity needs the inverse of the data XOR so the total count is odd.
   always_comb begin
      par_bit_c_o = 1'b0;
      case (parity_type_i)
         PAR_ODD:             par_bit_c_o = ~xor_c;
         PAR_EVEN:            par_bit_c_o = xor_c;
         PAR_NONE, PAR_NONE2: par_bit_c_o = 1'b0;
         default:             par_bit_c_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits, each held CLKS_PER_BIT clocks.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic [1:0]           parity_type,
   input  logic                 stop_bits,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   tx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [1:0]           ptype_q, ptype_d;
   logic                 stop2_q, stop2_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end_c;
   logic                 par_bit_c;

   assign bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   uart_parity #(
      .DATA_BITS (DATA_BITS)
   ) u_parity (
      .data_i        (data_q),
      .parity_type_i (ptype_q),
      .par_bit_c_o   (par_bit_c)
   );

   // State, counters, shadow registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         ptype_q <= PAR_NONE;
         stop2_q <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         ptype_q <= ptype_d;
         stop2_q <= stop2_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Frame sequencing; the line level is derived from the next state so it
   // changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      ptype_d = ptype_q;
      stop2_d = stop2_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      tx_d    = 1'b1;

      if (state_q != IDLE) begin
         cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               state_d = START;
               data_d  = data_in;
               ptype_d = parity_type;
               stop2_d = stop_bits;
               cnt_d   = '0;
               bit_d   = '0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end_c) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end_c) begin
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = parity_enabled(ptype_q) ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end_c) begin
               state_d = STOP;
               bit_d   = '0;
            end
         end
         STOP: begin
            // bit_q counts stop bits already sent.
            if (bit_end_c) begin
               if (stop2_q && (bit_q == '0)) begin
                  bit_d = BIT_W'(1);
               end else begin
                  state_d = IDLE;
                  bit_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_q[bit_d];
         PARITY:  tx_d = par_bit_c;
         default: tx_d = 1'b1;
      endcase
   end

   assign tx_out  = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected frames,
// a negedge monitor checks line, busy and done every cycle.
module tb_uart_tx_ctrl;

   localparam int unsigned C = 4;

   typedef struct {
      logic [7:0] d;
      logic [1:0] pt;
      logic       s2;
      int         acc;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [1:0] parity_type = 2'b00;
   logic       stop_bits = 1'b0;
   logic       tx_out, busy, tx_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int next_ok = 0;
   logic rst_seen = 1'b1;

   frame_t sb[$];
   logic   exp_q[$];
   bit     in_frame = 0;
   bit     done_pend = 0;

   uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
      .parity_type(parity_type), .stop_bits(stop_bits),
      .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   function automatic int frame_bits(input logic [1:0] pt, input logic s2);
      int p = (pt == 2'b01 || pt == 2'b10) ? 1 : 0;
      return 1 + 8 + p + (s2 ? 2 : 1);
   endfunction

   // Expected line waveform, one entry per clock, from the frame rules.
   task automatic build(input frame_t f);
      logic bits[$];
      int ones;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(f.d[i]);
      ones = $countones(f.d);
      if (f.pt == 2'b01) bits.push_back((ones % 2) == 0);
      if (f.pt == 2'b10) bits.push_back((ones % 2) == 1);
      bits.push_back(1'b1);
      if (f.s2) bits.push_back(1'b1);
      exp_q.delete();
      foreach (bits[i]) for (int k = 0; k < int'(C); k++) exp_q.push_back(bits[i]);
   endtask

   task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d {tx_out,busy,tx_done} got=%b expected=%b", name, cyc, got, exp);
      end
   endtask

   // Monitor: compares DUT outputs every cycle against the scoreboard.
   always @(negedge clk) begin
      logic   b;
      frame_t f;
      if (rst_seen) begin
         chk("reset", {tx_out, busy, tx_done}, 3'b100);
         in_frame  = 0;
         done_pend = 0;
         exp_q.delete();
      end else if (in_frame) begin
         b = exp_q.pop_front();
         chk("frame_bit", {tx_out, busy, tx_done}, {b, 2'b10});
         if (exp_q.size() == 0) begin
            in_frame  = 0;
            done_pend = 1;
         end
      end else if (done_pend) begin
         chk("done", {tx_out, busy, tx_done}, 3'b101);
         done_pend = 0;
      end else if (sb.size() > 0 && sb[0].acc == cyc) begin
         f = sb.pop_front();
         build(f);
         b = exp_q.pop_front();
         chk("start_bit", {tx_out, busy, tx_done}, {b, 2'b10});
         in_frame = 1;
      end else begin
         chk("idle", {tx_out, busy, tx_done}, 3'b100);
      end
   end

   task automatic scramble();
      data_in     = 8'($urandom);
      parity_type = 2'($urandom);
      stop_bits   = 1'($urandom);
   endtask

   // Issue one accepted frame; optionally pulse tx_start mid-frame.
   task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic s2, input bit pulse);
      int n, len;
      while (cyc + 1 < next_ok) @(negedge clk);
      data_in = d; parity_type = pt; stop_bits = s2; tx_start = 1'b1;
      n   = cyc + 1;
      len = frame_bits(pt, s2) * int'(C);
      sb.push_back('{d, pt, s2, n});
      next_ok = n + len + 1;
      @(negedge clk);
      tx_start = 1'b0;
      scramble();
      if (pulse) begin
         repeat ($urandom_range(1, len - 2)) @(negedge clk);
         scramble();
         tx_start = 1'b1;
         @(negedge clk);
         tx_start = 1'b0;
      end
   endtask

   initial begin
      int n, len;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      next_ok = cyc + 1;

      send(8'hA5, 2'b00, 1'b0, 0);
      send(8'hA5, 2'b01, 1'b1, 0);
      send(8'hA5, 2'b10, 1'b0, 0);
      send(8'h07, 2'b10, 1'b0, 0);
      send(8'h5A, 2'b11, 1'b1, 1);

      // Back-to-back with tx_start held high.
      while (cyc + 1 < next_ok) @(negedge clk);
      data_in = 8'h3C; parity_type = 2'b00; stop_bits = 1'b0; tx_start = 1'b1;
      n   = cyc + 1;
      len = frame_bits(2'b00, 1'b0) * int'(C);
      sb.push_back('{8'h3C, 2'b00, 1'b0, n});
      sb.push_back('{8'h3C, 2'b00, 1'b0, n + len + 1});
      next_ok = n + 2 * (len + 1);
      while (cyc < n + len + 1) @(negedge clk);
      tx_start = 1'b0;

      // Reset during data bit 3, then a clean frame.
      send(8'hFF, 2'b01, 1'b0, 0);
      while (cyc < sb.size() * 0 + next_ok - (frame_bits(2'b01, 1'b0) * int'(C) + 1) + 4 * int'(C) + 1)
         @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      next_ok = cyc + 1;
      send(8'hC3, 2'b10, 1'b1, 0);

      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(8'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1));
      end

      while (cyc < next_ok + 3) @(negedge clk);
      checks++;
      if (sb.size() != 0 || in_frame || done_pend) begin
         errors++;
         $display("FAIL drain pending_frames=%0d in_frame=%0d expected 0", sb.size(), in_frame);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d expected completion", cyc);
      $fatal(1);
   end

endmodule
